otter_reg_file_wb: RTL and testbench
====================================

Name: otter_reg_file_wb

Overview:
- 32x32 integer register file with integrated write-back select and load-data sizing.
- Read side drives RS1/RS2 operands into the ALU operand-select stage.
- Write side consumes ALU_RESULT, PC+4, CSR read data or sized memory load data and commits one register per clock.
- Sits between the instruction decoder (addresses, selects) and the ALU operand stage / data memory.

Parameters:
- XLEN, 32, data width of every register and write-back source.
- NREGS, 32, number of architectural registers; address width = $clog2(NREGS).

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- ADR1  in  5  read address, port 1.
- ADR2  in  5  read address, port 2.
- WA  in  5  write address.
- REG_WRITE  in  1  write enable.
- RF_WR_SEL  in  2  write-back source: 00 PC_PLUS4, 01 CSR_RD, 10 sized MEM_DOUT, 11 ALU_RESULT.
- PC_PLUS4  in  32  return address for JAL/JALR.
- CSR_RD  in  32  CSR read data.
- MEM_DOUT  in  32  raw word from data memory, word-aligned.
- MEM_FUNCT3  in  3  load size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- MEM_ADDR_LO  in  2  low two bits of the load byte address (equals ALU_RESULT[1:0] of the load).
- ALU_RESULT  in  32  ALU output.
- RS1  out  32  read data, port 1.
- RS2  out  32  read data, port 2.
- WD  out  32  selected, sized write-back value (observability / debug).

Behaviour:
- Clock and reset: one clock, CLK; reset is asynchronous and active-low, RST_N.
- Reset: while RST_N=0, all NREGS registers are cleared to 0 immediately (asynchronous). RS1/RS2 therefore read 0. WD stays combinational.
- Reset asserted mid-write: the write is lost. Registers hold 0 until the first rising CLK edge after RST_N deasserts.
- Reads: combinational, zero latency. RSn = reg[ADRn]. Address 0 always reads 0.
- Write: on posedge CLK, if REG_WRITE=1 and WA!=0, then reg[WA] <= WD. Writes to WA=0 are discarded. The result is visible on RS1/RS2 after the edge (one-cycle write latency).
- Read-during-write, same address, same cycle: RSn returns the old value (no bypass unless the optional feature is compiled in).
- WD mux: RF_WR_SEL as listed under Ports. Every code is defined; there is no X path.
- Load sizing (RF_WR_SEL=10):
  - Byte lane = MEM_ADDR_LO; halfword lane = MEM_ADDR_LO[1].
  - LB / LH sign-extend the selected lane to 32 bits.
  - LBU / LHU zero-extend the selected lane.
  - LW passes MEM_DOUT unchanged and ignores MEM_ADDR_LO.
  - Misaligned LH (MEM_ADDR_LO[0]=1) uses lane MEM_ADDR_LO[1]; no trap is raised.
  - Undefined MEM_FUNCT3 (011, 110, 111) behaves as LW.
- REG_WRITE=0: no register changes, regardless of all other inputs.
- No internal FSM beyond the storage array. All sequential state is the register array.

Optional Feature:
- Macro: RF_WRITE_BYPASS_EN.
- Defined: if REG_WRITE=1, WA!=0 and ADRn==WA, then RSn = WD combinationally in the same cycle (write-first forwarding for a pipelined neighbour). ADRn=0 still reads 0.
- Undefined: read-old-value behaviour as specified above. No forwarding logic is synthesised.

Test Plan:
- Reset clear: preload x5=0xDEADBEEF, assert RST_N=0 between edges -> RS1 (ADR1=5) reads 0x00000000 immediately, without waiting for CLK.
- x0 immutability: REG_WRITE=1, WA=0, RF_WR_SEL=11, ALU_RESULT=0x12345678, one edge -> RS1 (ADR1=0) = 0.
- Write/readback per source:
  - sel=00, PC_PLUS4=0x104 -> x1=0x104.
  - sel=01, CSR_RD=0x80 -> x2=0x80.
  - sel=11, ALU_RESULT=0xFFFFFFFF -> x31=0xFFFFFFFF.
  - RS1 and RS2 read x1 and x31 simultaneously with the correct values.
- Load sizing, MEM_DOUT=0x80F17F01, sel=10:
  - LB, ADR_LO=3 -> 0xFFFFFF80.
  - LBU, ADR_LO=3 -> 0x00000080.
  - LH, ADR_LO=2 -> 0xFFFF80F1.
  - LHU, ADR_LO=0 -> 0x00007F01.
  - LW -> 0x80F17F01.
- Read-during-write: x7=0x11, then write x7<=0x22 with ADR1=7 in the same cycle.
  - Without macro: RS1=0x11 before the edge, 0x22 after.
  - With RF_WRITE_BYPASS_EN: RS1=0x22 before the edge.
- REG_WRITE gating: REG_WRITE=0, WA=9, WD=0xAAAA5555 for 3 edges -> x9 keeps its prior value (0 after reset).

Source files
------------

// File: rtl/otter_reg_file_wb.sv
// -----------------------------------------------------------------------------
// otter_reg_file_wb
//
// Purpose:
//   32 x XLEN integer register file with an integrated write-back source mux
//   and load-data sizing. The decoder supplies addresses and selects. RS1 and
//   RS2 feed the ALU operand-select stage. The write side commits one register
//   per rising clock edge. x0 is hard-wired to zero and has no storage.
//
// Ports:
//   CLK          system clock, all state updates on the rising edge
//   RST_N        asynchronous active-low reset, clears every register
//   ADR1/ADR2    read addresses (combinational read ports)
//   WA           write address
//   REG_WRITE    write enable
//   RF_WR_SEL    write-back source: 00 PC_PLUS4, 01 CSR_RD,
//                10 sized MEM_DOUT, 11 ALU_RESULT
//   PC_PLUS4     return address for JAL/JALR
//   CSR_RD       CSR read data
//   MEM_DOUT     raw word-aligned load data
//   MEM_FUNCT3   load size/sign (LB, LH, LW, LBU, LHU; other codes act as LW)
//   MEM_ADDR_LO  low two bits of the load byte address
//   ALU_RESULT   ALU output
//   RS1/RS2      read data
//   WD           selected, sized write-back value (debug visibility)
//
// Configuration:
//   RF_WRITE_BYPASS_EN - when defined, a read of the register being written
//   in the same cycle returns WD (write-first forwarding). When undefined,
//   such a read returns the old register contents.
// -----------------------------------------------------------------------------
module otter_reg_file_wb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [AW-1:0]   ADR1,
  input  logic [AW-1:0]   ADR2,
  input  logic [AW-1:0]   WA,
  input  logic            REG_WRITE,
  input  logic [1:0]      RF_WR_SEL,
  input  logic [XLEN-1:0] PC_PLUS4,
  input  logic [XLEN-1:0] CSR_RD,
  input  logic [XLEN-1:0] MEM_DOUT,
  input  logic [2:0]      MEM_FUNCT3,
  input  logic [1:0]      MEM_ADDR_LO,
  input  logic [XLEN-1:0] ALU_RESULT,
  output logic [XLEN-1:0] RS1,
  output logic [XLEN-1:0] RS2,
  output logic [XLEN-1:0] WD
);

  // Storage only for x1..x(NREGS-1). Reads of x0 are forced to zero.
  logic [XLEN-1:0] regs [1:NREGS-1];

  logic [7:0]      load_byte;
  logic [15:0]     load_half;
  logic [XLEN-1:0] load_sized;
  logic            wr_en;

  // A write to x0 is discarded, so it never counts as a write.
  assign wr_en = REG_WRITE && (WA != '0);

  // ---------------------------------------------------------------------------
  // Load sizing. The byte lane is picked by both address bits. The halfword
  // lane is picked by bit 1 only. A misaligned LH therefore uses the lane that
  // contains its address and raises no trap.
  // ---------------------------------------------------------------------------
  always_comb begin
    load_byte = MEM_DOUT[7:0];
    case (MEM_ADDR_LO)
      2'd0:    load_byte = MEM_DOUT[7:0];
      2'd1:    load_byte = MEM_DOUT[15:8];
      2'd2:    load_byte = MEM_DOUT[23:16];
      default: load_byte = MEM_DOUT[31:24];
    endcase
  end

  assign load_half = MEM_ADDR_LO[1] ? MEM_DOUT[31:16] : MEM_DOUT[15:0];

  always_comb begin
    load_sized = MEM_DOUT;
    case (MEM_FUNCT3)
      3'b000:  load_sized = {{(XLEN-8){load_byte[7]}}, load_byte};
      3'b001:  load_sized = {{(XLEN-16){load_half[15]}}, load_half};
      3'b100:  load_sized = {{(XLEN-8){1'b0}}, load_byte};
      3'b101:  load_sized = {{(XLEN-16){1'b0}}, load_half};
      // LW and the undefined encodings pass the raw word through.
      default: load_sized = MEM_DOUT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write-back source mux. All four codes are defined, so there is no X path.
  // ---------------------------------------------------------------------------
  always_comb begin
    WD = ALU_RESULT;
    case (RF_WR_SEL)
      2'b00:   WD = PC_PLUS4;
      2'b01:   WD = CSR_RD;
      2'b10:   WD = load_sized;
      default: WD = ALU_RESULT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Register storage. Each register has its own flop process. The array must
  // clear asynchronously, so it is built from flops and not from block RAM.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 1; gi < NREGS; gi++) begin : g_reg
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          regs[gi] <= '0;
        end else if (wr_en && (WA == AW'(gi))) begin
          regs[gi] <= WD;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Read ports. These are combinational with zero latency, and x0 reads zero.
  // ---------------------------------------------------------------------------
  always_comb begin
    RS1 = '0;
    if (ADR1 != '0) begin
`ifdef RF_WRITE_BYPASS_EN
      if (wr_en && (ADR1 == WA)) RS1 = WD;
      else                       RS1 = regs[ADR1];
`else
      RS1 = regs[ADR1];
`endif
    end
  end

  always_comb begin
    RS2 = '0;
    if (ADR2 != '0) begin
`ifdef RF_WRITE_BYPASS_EN
      if (wr_en && (ADR2 == WA)) RS2 = WD;
      else                       RS2 = regs[ADR2];
`else
      RS2 = regs[ADR2];
`endif
    end
  end

endmodule

// File: tb/tb_otter_reg_file_wb.sv
// -----------------------------------------------------------------------------
// tb_otter_reg_file_wb
//
// Directed testbench for otter_reg_file_wb. Every expected value is a
// hand-computed constant. Inputs change one time unit after a rising edge.
// Outputs are sampled one time unit after the inputs change, or one time unit
// after a rising edge. Each comparison prints one line.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_otter_reg_file_wb;

  logic        clk;
  logic        rst_n;
  logic [4:0]  adr1, adr2, wa;
  logic        reg_write;
  logic [1:0]  rf_wr_sel;
  logic [31:0] pc_plus4, csr_rd, mem_dout, alu_result;
  logic [2:0]  mem_funct3;
  logic [1:0]  mem_addr_lo;
  logic [31:0] rs1, rs2, wd;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  otter_reg_file_wb dut (
    .CLK         (clk),
    .RST_N       (rst_n),
    .ADR1        (adr1),
    .ADR2        (adr2),
    .WA          (wa),
    .REG_WRITE   (reg_write),
    .RF_WR_SEL   (rf_wr_sel),
    .PC_PLUS4    (pc_plus4),
    .CSR_RD      (csr_rd),
    .MEM_DOUT    (mem_dout),
    .MEM_FUNCT3  (mem_funct3),
    .MEM_ADDR_LO (mem_addr_lo),
    .ALU_RESULT  (alu_result),
    .RS1         (rs1),
    .RS2         (rs2),
    .WD          (wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) begin
      pass_cnt++;
      $display("ok   %-14s got=%08h exp=%08h", tag, got, exp);
    end else begin
      $display("FAIL %-14s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Wait for one rising edge, then step away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write an ALU value to a register. The write takes effect on the next edge.
  task automatic wr_alu(input logic [4:0] a, input logic [31:0] v);
    wa = a; rf_wr_sel = 2'b11; alu_result = v; reg_write = 1'b1;
    tick();
    reg_write = 1'b0;
  endtask

  // Set up a load on the write-back path and check the sized WD value.
  task automatic load_chk(input string tag, input logic [2:0] f3,
                          input logic [1:0] lo, input logic [31:0] exp);
    rf_wr_sel = 2'b10; mem_funct3 = f3; mem_addr_lo = lo;
    #1;
    check(tag, wd, exp);
  endtask

  initial begin
    rst_n = 1'b0; adr1 = '0; adr2 = '0; wa = '0; reg_write = 1'b0;
    rf_wr_sel = 2'b11; pc_plus4 = '0; csr_rd = '0; mem_dout = '0;
    alu_result = '0; mem_funct3 = 3'b010; mem_addr_lo = '0;

    // Reset state and release.
    adr1 = 5'd5; adr2 = 5'd31;
    #2;
    check("rst_rs1", rs1, 32'h0);
    check("rst_rs2", rs2, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Preload x5, then assert reset between edges. It must clear at once.
    wr_alu(5'd5, 32'hDEADBEEF);
    check("preload_x5", rs1, 32'hDEADBEEF);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear", rs1, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("x5_after_rst", rs1, 32'h0);

    // A write pending when reset asserts is lost.
    wa = 5'd10; rf_wr_sel = 2'b11; alu_result = 32'h55; reg_write = 1'b1; adr1 = 5'd10;
    rst_n = 1'b0;
    tick();
    reg_write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst_mid_wr", rs1, 32'h0);

    // x0 cannot be changed.
    wa = 5'd0; rf_wr_sel = 2'b11; alu_result = 32'h12345678; reg_write = 1'b1; adr1 = 5'd0;
    #1;
    check("wd_alu", wd, 32'h12345678);
    tick();
    reg_write = 1'b0;
    check("x0_zero", rs1, 32'h0);

    // Write and read back each write-back source.
    wa = 5'd1; rf_wr_sel = 2'b00; pc_plus4 = 32'h104; reg_write = 1'b1;
    tick();
    wa = 5'd2; rf_wr_sel = 2'b01; csr_rd = 32'h80;
    tick();
    wa = 5'd31; rf_wr_sel = 2'b11; alu_result = 32'hFFFFFFFF;
    tick();
    reg_write = 1'b0;
    adr1 = 5'd1; adr2 = 5'd31;
    #1;
    check("x1_pc4", rs1, 32'h104);
    check("x31_alu", rs2, 32'hFFFFFFFF);
    adr2 = 5'd2;
    #1;
    check("x2_csr", rs2, 32'h80);

    // Load sizing on MEM_DOUT = 0x80F17F01.
    mem_dout = 32'h80F17F01;
    load_chk("lb_lo3",    3'b000, 2'd3, 32'hFFFFFF80);
    load_chk("lbu_lo3",   3'b100, 2'd3, 32'h00000080);
    load_chk("lh_lo2",    3'b001, 2'd2, 32'hFFFF80F1);
    load_chk("lhu_lo0",   3'b101, 2'd0, 32'h00007F01);
    load_chk("lw",        3'b010, 2'd2, 32'h80F17F01);
    load_chk("lb_lo1",    3'b000, 2'd1, 32'h0000007F);
    load_chk("lbu_lo2",   3'b100, 2'd2, 32'h000000F1);
    load_chk("lh_mis1",   3'b001, 2'd1, 32'h00007F01);
    load_chk("lhu_mis3",  3'b101, 2'd3, 32'h000080F1);
    load_chk("undef_011", 3'b011, 2'd1, 32'h80F17F01);
    load_chk("undef_111", 3'b111, 2'd3, 32'h80F17F01);

    // Commit a sized load and read it back.
    mem_funct3 = 3'b000; mem_addr_lo = 2'd3; wa = 5'd3; reg_write = 1'b1;
    tick();
    reg_write = 1'b0;
    adr1 = 5'd3;
    #1;
    check("x3_lb", rs1, 32'hFFFFFF80);

    // Read during write to the same address.
    wr_alu(5'd7, 32'h11);
    wa = 5'd7; rf_wr_sel = 2'b11; alu_result = 32'h22; reg_write = 1'b1;
    adr1 = 5'd7; adr2 = 5'd0;
    #1;
`ifdef RF_WRITE_BYPASS_EN
    check("rdw_before", rs1, 32'h22);
`else
    check("rdw_before", rs1, 32'h11);
`endif
    check("rdw_x0", rs2, 32'h0);
    tick();
    reg_write = 1'b0;
    check("rdw_after", rs1, 32'h22);

    // REG_WRITE low blocks all writes.
    wa = 5'd9; rf_wr_sel = 2'b11; alu_result = 32'hAAAA5555; reg_write = 1'b0;
    adr2 = 5'd9;
    #1;
    check("gate_wd", wd, 32'hAAAA5555);
    for (int i = 0; i < 3; i++) tick();
    check("gate_x9", rs2, 32'h0);
    adr1 = 5'd7;
    #1;
    check("gate_x7", rs1, 32'h22);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
